serial_subtractor: RTL

Bit-serial N-bit subtractor that computes z = x − y − bi one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow. It is the sequential stage built around the full-subtractor cell: it serialises parallel operands into the cell and reassembles the difference. Operands arrive on a valid/ready input handshake, and results leave on a valid/ready output handshake. It is the area-minimal subtract path beside the parallel ripple subtractor.

---
 rtl/serial_sub_pkg.sv | 8 +
 rtl/fsc_bit.sv | 11 +
 rtl/serial_subtractor.sv | 78 +++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM states, default width and counter-width helper for serial_subtractor
package serial_sub_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int DEF_WIDTH = 8;
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/fsc_bit.sv
// fsc_bit: combinational one-bit full-subtractor cell, z = x - y - bi
module fsc_bit (
  input  logic bi,
  input  logic x,
  input  logic y,
  output logic z,
  output logic bo
);
  assign z  = x ^ y ^ bi;
  assign bo = (~x & y) | (~x & bi) | (y & bi);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial x - y - bi, LSB first, with valid/ready handshakes; SERIAL_SUB_OVF_EN adds the ovf output
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             bo
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = cnt_w(WIDTH);
  state_t           r_state;
  logic [WIDTH-1:0] r_x_sr, r_y_sr, r_z_sr;
  logic             r_brw;
  logic [CW-1:0]    r_cnt;
  logic             w_d, w_b, w_load, w_last;
  fsc_bit u_cell (
    .bi (r_brw),
    .x  (r_x_sr[0]),
    .y  (r_y_sr[0]),
    .z  (w_d),
    .bo (w_b)
  );
  assign in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
  assign w_load    = in_valid & in_ready;
  assign w_last    = r_cnt == CW'(WIDTH - 1);
  assign out_valid = r_state == DONE;
  assign z         = r_z_sr;
  assign bo        = r_brw;
  // load operands on handshake, step the cell once per SHIFT cycle, release DONE on out_ready
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_x_sr  <= '0;
      r_y_sr  <= '0;
      r_z_sr  <= '0;
      r_brw   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_state <= SHIFT;
      r_x_sr  <= x;
      r_y_sr  <= y;
      r_brw   <= bi;
      r_cnt   <= '0;
    end else if (r_state == SHIFT) begin
      r_x_sr  <= r_x_sr >> 1;
      r_y_sr  <= r_y_sr >> 1;
      r_z_sr  <= {w_d, r_z_sr[WIDTH-1:1]};
      r_brw   <= w_b;
      r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
      r_state <= w_last ? DONE : SHIFT;
    end else if (r_state == DONE && out_ready)
      r_state <= IDLE;
    else if (r_state != IDLE && r_state != DONE)
      r_state <= IDLE;
`ifdef SERIAL_SUB_OVF_EN
  logic r_brw_msb;
  // borrow into the MSB, captured on the final shift step, gives signed overflow against the final borrow
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      r_brw_msb <= 1'b0;
    else if (r_state == SHIFT && w_last && !w_load)
      r_brw_msb <= r_brw;
  assign ovf = r_brw_msb ^ r_brw;
`endif
endmodule
